// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage ASIP pipeline
module pipe_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              MultiE,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              Busy,
  output logic [CNT_W-1:0]  StallCnt
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  localparam logic [REG_AW-1:0] PC_IDX  = REG_AW'(PC_REG);
  localparam logic [3:0]        MC_INIT = 4'(MC_LAT - 2);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       mem_wait, ld_use, mc_stall;
  logic [1:0] fwd_a, fwd_b;

  assign mem_wait = MemReqM & ~MemAckM;
  assign ld_use   = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign mc_stall = ((state_q == RUN) & MultiE) | ((state_q == MC_BUSY) & (cnt_q != 4'd0));

  // M result wins over W; the PC is never forwarded
  assign fwd_a = (RegWriteM && WA3M == RA1E && RA1E != PC_IDX) ? 2'b10 :
                 (RegWriteW && WA3W == RA1E && RA1E != PC_IDX) ? 2'b01 : 2'b00;
  assign fwd_b = (RegWriteM && WA3M == RA2E && RA2E != PC_IDX) ? 2'b10 :
                 (RegWriteW && WA3W == RA2E && RA2E != PC_IDX) ? 2'b01 : 2'b00;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    Busy      = (state_q == MC_BUSY);

    if (mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mc_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
      if (state_q == RUN) begin
        cnt_d   = MC_INIT;
        state_d = MC_BUSY;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else begin
      // MC_BUSY with cnt==0 is the release cycle; branch/load-use still apply
      if (state_q == MC_BUSY) state_d = RUN;
      if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (ld_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    // pipeline inputs may still be live during reset; keep the controls quiet
    if (!rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      Busy      = 1'b0;
    end
  end

  assign stall_cnt_d = (StallF && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign StallCnt    = stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 4;
  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MultiE, MemReqM, MemAckM;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, Busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [15:0] StallCnt;

  logic s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushM, s_FlushW, s_Busy;
  logic [1:0] s_ForwardAE, s_ForwardBE;
  logic [1:0] s_StallCnt;

  int n_checks = 0;
  int n_errors = 0;
  int age  = 0;   // E cycles the current multi-cycle op has already spent (0 = none)
  int scnt = 0;   // stalled cycles since reset

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .PC_REG(15), .MC_LAT(MC_LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MultiE(MultiE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Busy(Busy), .StallCnt(StallCnt)
  );

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .PC_REG(15), .MC_LAT(MC_LAT), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MultiE(MultiE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
    .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushM(s_FlushM), .FlushW(s_FlushW),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .Busy(s_Busy), .StallCnt(s_StallCnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; BranchTakenE = 1'b0; MultiE = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Called just after the falling edge once inputs are set; compares, then advances the model
  task automatic eval_cycle();
    logic mw, lu, mcs;
    logic sf, sd, se, sm, fd, fe, fm, fw;
    logic [12:0] exp_v, obs_v, obs_s;
    int lim16, lim2;
    #1;
    mw  = MemReqM && !MemAckM;
    lu  = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    mcs = (age == 0 && MultiE) || (age > 0 && age < MC_LAT - 1);
    {sf, sd, se, sm, fd, fe, fm, fw} = 8'h00;
    if (mw)                begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
    else if (mcs)          begin sf = 1; sd = 1; se = 1; fm = 1; end
    else if (BranchTakenE) begin fd = 1; fe = 1; end
    else if (lu)           begin sf = 1; sd = 1; fe = 1; end
    exp_v = {sf, sd, se, sm, fd, fe, fm, fw, ref_fwd(RA1E), ref_fwd(RA2E), logic'(age > 0)};
    obs_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ForwardAE, ForwardBE, Busy};
    obs_s = {s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushM, s_FlushW,
             s_ForwardAE, s_ForwardBE, s_Busy};
    lim16 = (scnt > 65535) ? 65535 : scnt;
    lim2  = (scnt > 3) ? 3 : scnt;
    check_eq("outputs", 32'(obs_v), 32'(exp_v));
    check_eq("outputs_cnt2", 32'(obs_s), 32'(exp_v));
    check_eq("stall_cnt", 32'(StallCnt), 32'(lim16));
    check_eq("stall_cnt_sat", 32'(s_StallCnt), 32'(lim2));
    if (!mw) age = mcs ? age + 1 : 0;
    if (sf) scnt++;
  endtask

  task automatic step();
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    MultiE = 1'b1; MemReqM = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
    RegWriteM = 1'b1; WA3M = 4'd1; RA1E = 4'd1;
    #3;
    check_eq("reset_quiet", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                                ForwardAE, ForwardBE, Busy}), 32'd0);
    check_eq("reset_cnt", 32'(StallCnt), 32'd0);
    repeat (2) @(negedge clk);
    drive_idle();
    rst = 1'b1;

    // multi-cycle op held in E: 3 stall cycles, Busy on cycles 2-4
    for (int k = 0; k < 4; k++) begin
      step(); MultiE = 1'b1; eval_cycle();
      check_eq("mc_stalle", 32'(StallE), 32'(k < 3));
      check_eq("mc_flushm", 32'(FlushM), 32'(k < 3));
      check_eq("mc_busy", 32'(Busy), 32'(k > 0));
    end
    step(); eval_cycle();
    check_eq("mc_stallcnt", 32'(StallCnt), 32'd3);

    // load-use then M forwarding of the loaded register
    step(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd3; RA1D = 4'd3; eval_cycle();
    check_eq("lu_ctrl", 32'({StallF, StallD, FlushE, StallE}), 32'b1110);
    step(); RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; eval_cycle();
    check_eq("lu_fwd", 32'(ForwardAE), 32'd2);

    // M beats W; PC never forwarded
    step(); RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd5; WA3W = 4'd5; RA2E = 4'd5; eval_cycle();
    check_eq("fwd_prio", 32'(ForwardBE), 32'd2);
    step(); RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA2E = 4'd15; eval_cycle();
    check_eq("fwd_pc", 32'(ForwardBE), 32'd0);

    // memory wait while MC_BUSY with one stall cycle left
    step(); MultiE = 1'b1; eval_cycle();
    step(); MultiE = 1'b1; eval_cycle();
    for (int k = 0; k < 2; k++) begin
      step(); MultiE = 1'b1; MemReqM = 1'b1; eval_cycle();
      check_eq("mw_stallm_flushw", 32'({StallM, FlushW, FlushM}), 32'b110);
    end
    step(); MultiE = 1'b1; MemReqM = 1'b1; MemAckM = 1'b1; eval_cycle();
    check_eq("mw_resume_stall", 32'({StallE, StallM, Busy}), 32'b101);
    step(); MultiE = 1'b1; eval_cycle();
    check_eq("mw_release", 32'({StallE, Busy}), 32'b01);
    step(); eval_cycle();
    check_eq("mw_done", 32'(Busy), 32'd0);

    // branch beats load-use; branch under memory wait flushes only on ack
    step(); BranchTakenE = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; eval_cycle();
    check_eq("br_lu", 32'({FlushD, FlushE, StallF}), 32'b110);
    for (int k = 0; k < 2; k++) begin
      step(); BranchTakenE = 1'b1; MemReqM = 1'b1; eval_cycle();
      check_eq("br_mw_hold", 32'({FlushD, FlushE, StallE}), 32'b001);
    end
    step(); BranchTakenE = 1'b1; MemReqM = 1'b1; MemAckM = 1'b1; eval_cycle();
    check_eq("br_ack", 32'({FlushD, FlushE, StallE}), 32'b110);

    // async reset mid MC_BUSY (cnt=2), no clock edge needed
    step(); MultiE = 1'b1; eval_cycle();
    @(negedge clk);
    MultiE = 1'b1; MemReqM = 1'b1; RegWriteM = 1'b1; WA3M = 4'd2; RA1E = 4'd2;
    #1;
    check_eq("pre_rst_busy", 32'(Busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_async_outs", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                                   ForwardAE, ForwardBE, Busy}), 32'd0);
    check_eq("rst_async_cnt", 32'(StallCnt), 32'd0);
    age = 0; scnt = 0;
    @(negedge clk);
    drive_idle();
    rst = 1'b1;

    // saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      step(); MemReqM = 1'b1; eval_cycle();
    end
    step(); eval_cycle();
    check_eq("sat_cnt2", 32'(s_StallCnt), 32'd3);
    check_eq("sat_cnt16", 32'(StallCnt), 32'd5);

    // randomized traffic with small register ranges so matches are frequent
    for (int n = 0; n < 4000; n++) begin
      step();
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      RA2E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3));
      WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3W = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      BranchTakenE = ($urandom_range(0, 4) == 0);
      MultiE  = ($urandom_range(0, 5) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      MemAckM = ($urandom_range(0, 1) == 0);
      eval_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
